// File: rtl/vector_store_unit.sv
// rtl/vector_store_unit.sv - latch a result vector and stream it to data memory in L-lane chunks; VSTORE_STRIDE_EN enables strided addressing
module vector_store_unit #(
   parameter int N = 32,
   parameter int V = 20,
   parameter int L = 4,
   parameter int A = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic [A-1:0]          addr_i,
   input  logic [A-1:0]          stride_i,
   input  logic [V-1:0][N-1:0]   vector_i,
   input  logic                  mem_ready_i,
   output logic [L-1:0]          MemWE_o,
   output logic [L-1:0][A-1:0]   MemAddr_o,
   output logic [L-1:0][N-1:0]   MemWD_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int C  = (V + L - 1) / L;
   localparam int KW = (C > 1) ? $clog2(C) : 1;
   localparam int IW = (V > 1) ? $clog2(V) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(C - 1);

   typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

   state_t              state, state_n;
   logic [KW-1:0]       k, k_n;
   logic                load;
   logic [V-1:0][N-1:0] vec_q, vec_src;
   logic [A-1:0]        base_q, base_src;
   logic [L-1:0]        we_n;
   logic [L-1:0][A-1:0] addr_n;
   logic [L-1:0][N-1:0] wd_n;
   int                  e;
`ifdef VSTORE_STRIDE_EN
   logic [A-1:0]        stride_q, stride_src;
`else
   logic                unused_stride;
   assign unused_stride = ^stride_i;
`endif

   // State and chunk index register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
      end
   end

   // Next state: accept a start only when not storing, advance chunk on accepted handshake
   always_comb begin
      state_n = state;
      k_n     = k;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_n = STORE;
               k_n     = '0;
               load    = 1'b1;
            end
         end
         STORE: begin
            if (mem_ready_i) begin
               if (k == K_LAST) state_n = DONE;
               else             k_n = k + KW'(1);
            end
         end
         DONE: begin
            k_n = '0;
            if (start_i) begin
               state_n = STORE;
               load    = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            k_n     = '0;
         end
      endcase
   end

   // Latched operands; frozen for the whole store so a mid-store start has no effect
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vec_q    <= '0;
         base_q   <= '0;
`ifdef VSTORE_STRIDE_EN
         stride_q <= '0;
`endif
      end else if (load) begin
         vec_q    <= vector_i;
         base_q   <= addr_i;
`ifdef VSTORE_STRIDE_EN
         stride_q <= stride_i;
`endif
      end
   end

   // Next chunk contents, taken from the incoming operands on the cycle they are latched
   always_comb begin
      we_n     = '0;
      addr_n   = '0;
      wd_n     = '0;
      e        = 0;
      vec_src  = load ? vector_i : vec_q;
      base_src = load ? addr_i : base_q;
`ifdef VSTORE_STRIDE_EN
      stride_src = load ? stride_i : stride_q;
`endif
      if (state_n == STORE) begin
         for (int j = 0; j < L; j++) begin
            e = int'(k_n) * L + j;
            if (e < V) begin
               we_n[j] = 1'b1;
               wd_n[j] = vec_src[IW'(e)];
`ifdef VSTORE_STRIDE_EN
               addr_n[j] = base_src + A'(e) * stride_src;
`else
               addr_n[j] = base_src + A'(e);
`endif
            end
         end
      end
   end

   // Registered outputs; a stalled chunk recomputes identically so it is held
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         MemWE_o   <= '0;
         MemAddr_o <= '0;
         MemWD_o   <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         MemWE_o   <= we_n;
         MemAddr_o <= addr_n;
         MemWD_o   <= wd_n;
         busy_o    <= (state_n == STORE);
         done_o    <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_vector_store_unit.sv
// tb/tb_vector_store_unit.sv - randomized self-checking bench for vector_store_unit
module tb_vector_store_unit;
   localparam int N  = 32;
   localparam int V  = 20;
   localparam int L  = 4;
   localparam int A  = 32;
   localparam int C  = (V + L - 1) / L;
   localparam int V1 = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                 start, mem_ready, busy, done;
   logic [A-1:0]         addr, stride;
   logic [V-1:0][N-1:0]  vec_in;
   logic [L-1:0]         we;
   logic [L-1:0][A-1:0]  maddr;
   logic [L-1:0][N-1:0]  mwd;

   logic                 start1, ready1, busy1, done1;
   logic [A-1:0]         addr1, stride1;
   logic [V1-1:0][N-1:0] vec1;
   logic [L-1:0]         we1;
   logic [L-1:0][A-1:0]  maddr1;
   logic [L-1:0][N-1:0]  mwd1;

   vector_store_unit #(.N(N), .V(V), .L(L), .A(A)) u0 (
      .CLK(clk), .RST(rst), .start_i(start), .addr_i(addr), .stride_i(stride),
      .vector_i(vec_in), .mem_ready_i(mem_ready), .MemWE_o(we), .MemAddr_o(maddr),
      .MemWD_o(mwd), .busy_o(busy), .done_o(done));

   vector_store_unit #(.N(N), .V(V1), .L(L), .A(A)) u1 (
      .CLK(clk), .RST(rst), .start_i(start1), .addr_i(addr1), .stride_i(stride1),
      .vector_i(vec1), .mem_ready_i(ready1), .MemWE_o(we1), .MemAddr_o(maddr1),
      .MemWD_o(mwd1), .busy_o(busy1), .done_o(done1));

   int n_vec = 0;
   int n_err = 0;

   logic [N-1:0]   ref_vec [V];
   logic [A+N-1:0] exp_q [$];
   logic [A+N-1:0] got_q [$];
   int done_cyc, busy_cnt, hold_err, lane_err, acc, stall_cnt;
   logic first_busy;

   // Reference: every element written exactly once, in element order, at base + e*step
   task automatic model_store(input logic [A-1:0] base, input logic [A-1:0] st);
      logic [A-1:0] step;
      logic [A-1:0] a;
      exp_q.delete();
`ifdef VSTORE_STRIDE_EN
      step = st;
`else
      step = (st == st) ? 1 : 0;
`endif
      for (int i = 0; i < V; i++) begin
         a = base + A'(i) * step;
         exp_q.push_back({a, ref_vec[i]});
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < V; i++) ref_vec[i] = $urandom;
   endtask

   // Drives one store on u0 from a negedge and records what memory accepted
   task automatic do_store(input logic [A-1:0] base, input logic [A-1:0] st,
                           input int mode, input int pulse_cyc);
      logic [L-1:0]        pwe;
      logic [L-1:0][A-1:0] paddr;
      logic [L-1:0][N-1:0] pwd;
      logic                pstall, r;
      got_q.delete();
      done_cyc = 0; busy_cnt = 0; hold_err = 0; lane_err = 0; acc = 0; stall_cnt = 0;
      first_busy = 1'b0; pstall = 1'b0; pwe = '0; paddr = '0; pwd = '0;
      addr = base; stride = st;
      for (int i = 0; i < V; i++) vec_in[i] = ref_vec[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (c == 1) first_busy = busy;
         if (done) begin
            done_cyc = c;
            break;
         end
         if (busy) busy_cnt++;
         if (c == pulse_cyc) begin
            start = 1'b1;
            addr  = ~base;
            for (int i = 0; i < V; i++) vec_in[i] = ~ref_vec[i];
         end else begin
            start = 1'b0;
         end
         if (pstall && (we !== pwe || maddr !== paddr || mwd !== pwd)) hold_err++;
         for (int j = 0; j < L; j++)
            if (!we[j] && (maddr[j] !== '0 || mwd[j] !== '0)) lane_err++;
         if (mode == 0)      r = 1'b1;
         else if (mode == 1) r = !(c == 2 || c == 3);
         else                r = ($urandom_range(0, 3) != 0);
         mem_ready = r;
         if (we != '0) begin
            if (r) begin
               acc++;
               for (int j = 0; j < L; j++)
                  if (we[j]) got_q.push_back({maddr[j], mwd[j]});
            end else begin
               stall_cnt++;
            end
         end
         pstall = !r && (we != '0);
         pwe = we; paddr = maddr; pwd = mwd;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (we !== '0 || we1 !== '0) begin n_err++; $display("FAIL reset_we got %b/%b exp 0", we, we1); end
      n_vec++; if (maddr !== '0 || mwd !== '0) begin n_err++; $display("FAIL reset_addr_data got %h %h exp 0", maddr, mwd); end
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done); end
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (we !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got we=%b busy=%b done=%b exp 0", we, busy, done); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < V; i++) ref_vec[i] = N'(2 * i);
      model_store(100, 1);
      do_store(100, 1, 0, 0);
      n_vec++; if (done_cyc != C + 1) begin n_err++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, C + 1); end
      n_vec++; if (busy_cnt != C) begin n_err++; $display("FAIL basic_busy_cycles got %0d exp %0d", busy_cnt, C); end
      n_vec++; if (first_busy !== 1'b1) begin n_err++; $display("FAIL basic_latency got busy=%b exp 1", first_busy); end
      n_vec++; if (got_q.size() != V) begin n_err++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), V); end
      for (int i = 0; i < V && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < V; i++) ref_vec[i] = N'(2 * i);
      model_store(100, 1);
      do_store(100, 1, 1, 0);
      n_vec++; if (done_cyc != 8) begin n_err++; $display("FAIL stall_done_cycle got %0d exp 8", done_cyc); end
      n_vec++; if (acc != C) begin n_err++; $display("FAIL stall_chunks got %0d exp %0d", acc, C); end
      n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL stall_hold got %0d changes exp 0", hold_err); end
      n_vec++; if (got_q.size() != V) begin n_err++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), V); end
      for (int i = 0; i < V && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_ignore_start_back_to_back();
      logic [A-1:0] b;
      fill_random();
      b = $urandom;
      model_store(b, 3);
      do_store(b, 3, 0, 3);
      n_vec++; if (done_cyc != C + 1) begin n_err++; $display("FAIL ignore_done_cycle got %0d exp %0d", done_cyc, C + 1); end
      n_vec++; if (got_q.size() != V) begin n_err++; $display("FAIL ignore_count got %0d exp %0d", got_q.size(), V); end
      for (int i = 0; i < V && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ignore_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      fill_random();
      b = $urandom;
      model_store(b, 5);
      do_store(b, 5, 0, 0);
      n_vec++; if (first_busy !== 1'b1) begin n_err++; $display("FAIL b2b_start got busy=%b exp 1", first_busy); end
      n_vec++; if (done_cyc != C + 1) begin n_err++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_cyc, C + 1); end
      n_vec++; if (got_q.size() != V) begin n_err++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), V); end
      for (int i = 0; i < V && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_short_vector();
      int bad;
      for (int i = 0; i < V1; i++) vec1[i] = N'(i + 256);
      addr1 = '0; stride1 = 1; ready1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      bad = 0;
      for (int j = 0; j < L; j++) if (maddr1[j] !== A'(j) || mwd1[j] !== N'(j + 256)) bad++;
      n_vec++; if (we1 !== 4'b1111 || busy1 !== 1'b1) begin n_err++; $display("FAIL short_chunk0_we got %b busy=%b exp 1111 1", we1, busy1); end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL short_chunk0_lanes got %h/%h exp addr 0..3 data 100..103", maddr1, mwd1); end
      @(negedge clk);
      n_vec++; if (we1 !== 4'b0011) begin n_err++; $display("FAIL short_chunk1_we got %b exp 0011", we1); end
      n_vec++; if (maddr1[0] !== A'(4) || maddr1[1] !== A'(5) || mwd1[0] !== N'(260) || mwd1[1] !== N'(261)) begin
         n_err++; $display("FAIL short_chunk1_live got %h/%h exp addr 4,5 data 104,105", maddr1, mwd1); end
      n_vec++; if (maddr1[2] !== '0 || maddr1[3] !== '0 || mwd1[2] !== '0 || mwd1[3] !== '0) begin
         n_err++; $display("FAIL short_chunk1_dead got %h/%h exp lanes 2-3 zero", maddr1, mwd1); end
      @(negedge clk);
      n_vec++; if (done1 !== 1'b1 || we1 !== '0 || busy1 !== 1'b0) begin n_err++; $display("FAIL short_done got done=%b we=%b busy=%b exp 1 0 0", done1, we1, busy1); end
      @(negedge clk);
      n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL short_done_pulse got %b exp 0", done1); end
   endtask

   task automatic test_reset_abort();
      int writes;
      fill_random();
      addr = $urandom; stride = 1; mem_ready = 1'b1;
      for (int i = 0; i < V; i++) vec_in[i] = ref_vec[i];
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (we !== 4'b1111 || maddr[0] !== addr + A'(8)) begin n_err++; $display("FAIL abort_pre got we=%b addr0=%h exp 1111 %h", we, maddr[0], addr + A'(8)); end
      rst = 1'b1;
      #1;
      n_vec++; if (we !== '0 || maddr !== '0 || mwd !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL abort_immediate got we=%b busy=%b done=%b exp all 0", we, busy, done); end
      @(negedge clk); rst = 1'b0;
      writes = 0;
      for (int c = 0; c < 8; c++) begin
         if (we !== '0 || done !== 1'b0) writes++;
         @(negedge clk);
      end
      n_vec++; if (writes != 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles exp 0", writes); end
      fill_random();
      model_store(32'hFFFF_FFFC, 4);
      do_store(32'hFFFF_FFFC, 4, 0, 0);
      n_vec++; if (done_cyc != C + 1) begin n_err++; $display("FAIL wrap_done_cycle got %0d exp %0d", done_cyc, C + 1); end
      for (int i = 0; i < V && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [A-1:0] b, s;
      for (int t = 0; t < 6; t++) begin
         fill_random();
         b = $urandom; s = $urandom_range(0, 64);
         model_store(b, s);
         do_store(b, s, 2, 0);
         n_vec++; if (done_cyc != C + stall_cnt + 1) begin n_err++; $display("FAIL rand%0d_done_cycle got %0d exp %0d", t, done_cyc, C + stall_cnt + 1); end
         n_vec++; if (acc != C) begin n_err++; $display("FAIL rand%0d_chunks got %0d exp %0d", t, acc, C); end
         n_vec++; if (hold_err != 0 || lane_err != 0) begin n_err++; $display("FAIL rand%0d_hold_lanes got %0d/%0d exp 0/0", t, hold_err, lane_err); end
         n_vec++; if (got_q.size() != V) begin n_err++; $display("FAIL rand%0d_count got %0d exp %0d", t, got_q.size(), V); end
         for (int i = 0; i < V && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_write[%0d] got %h exp %h", t, i, got_q[i], exp_q[i]); end
         end
         if (t[0]) @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mem_ready = 1'b1; addr = '0; stride = '0; vec_in = '0;
      start1 = 1'b0; ready1 = 1'b1; addr1 = '0; stride1 = '0; vec1 = '0;
      test_reset();
      test_basic();
      test_stall();
      test_ignore_start_back_to_back();
      test_short_vector();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
